// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage, producer side of the decode input.
//
// Keeps the PC and issues one-word reads to a synchronous instruction memory
// with 1-cycle latency. It splits each returned word into decode fields and
// buffers responses in a small FIFO, so a decode stall never loses a word.
// A redirect flushes everything buffered and restarts fetch at the target.
//
// Ports:
//   clock_i              clock, rising edge
//   resetn_i             synchronous reset, active-low
//   enable_i             fetch run enable (0 = issue no new requests)
//   stall_i              decode stall; the output stage holds
//   redirect_i           branch redirect pulse
//   redirectAddr_i       redirect target
//   imemReq_o            memory read request
//   imemAddr_o           memory read address
//   imemValid_i          read data valid, one cycle after the request
//   imemData_i           instruction word
//   enable_o             output fields valid
//   isBranch_o           word[29]
//   instructionFormat_o  word[28] (1 = reg-imm, 0 = reg-reg)
//   opcode_o             word[27:21]
//   primOperand_o        word[20:16]
//   secOperand_o         word[15:0]
//   pc_o                 address of the word on the outputs
//   flushBack_o          one-cycle flush pulse to decode
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              enable_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirectAddr_i,
  output logic              imemReq_o,
  output logic [ADDR_W-1:0] imemAddr_o,
  input  logic              imemValid_i,
  input  logic [31:0]       imemData_i,
  output logic              enable_o,
  output logic              isBranch_o,
  output logic              instructionFormat_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        primOperand_o,
  output logic [15:0]       secOperand_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flushBack_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: PC and request issue
  logic [ADDR_W-1:0] pc_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;

  // Stage p1: response capture and FIFO
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              drop_p1;
  logic [29:0]       fifo_word [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  // Stage p2: registered decode outputs
  logic              vld_p2;
  logic [29:0]       word_p2;
  logic [ADDR_W-1:0] pc_p2;
  logic              flush_p2;

  logic              consume;
  logic              out_free;
  logic              rsp_take;
  logic              fifo_empty;
  logic              load_head;
  logic              bypass;
  logic              push;
  logic [CNT_W:0]    occ;
  logic              issue;
  logic              unused_hi;

  assign unused_hi  = &{1'b0, imemData_i[31:30]};

  assign consume    = vld_p2 & ~stall_i;
  assign out_free   = ~vld_p2 | consume;
  assign rsp_take   = imemValid_i & vld_p1 & ~drop_p1 & ~redirect_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign load_head  = out_free & ~fifo_empty;
  assign bypass     = out_free & fifo_empty & rsp_take;
  assign push       = rsp_take & ~bypass;

  // A response landing in the FIFO this cycle already owns a slot, and the
  // request on the bus now will need one next cycle; a pop is not credited.
  assign occ   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, push} + {{CNT_W{1'b0}}, vld_p0};
  assign issue = enable_i & (occ < (CNT_W + 1)'(DEPTH));

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      pc_p0    <= RESET_PC;
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      vld_p1   <= 1'b0;
      drop_p1  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      vld_p2   <= 1'b0;
      word_p2  <= '0;
      pc_p2    <= '0;
      flush_p2 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (redirect_i) begin
        pc_p0    <= redirectAddr_i;
        vld_p0   <= 1'b0;
        drop_p1  <= vld_p0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
        vld_p2   <= 1'b0;
        flush_p2 <= 1'b1;
      end else begin
        flush_p2 <= 1'b0;
        drop_p1  <= 1'b0;
        if (issue) begin
          vld_p0  <= 1'b1;
          addr_p0 <= pc_p0;
          pc_p0   <= pc_p0 + 1'b1;
        end else begin
          vld_p0  <= 1'b0;
        end
        if (load_head) begin
          vld_p2  <= 1'b1;
          word_p2 <= fifo_word[rd_ptr];
          pc_p2   <= fifo_pc[rd_ptr];
          rd_ptr  <= ptr_inc(rd_ptr);
        end else if (bypass) begin
          vld_p2  <= 1'b1;
          word_p2 <= imemData_i[29:0];
          pc_p2   <= addr_p1;
        end else if (consume) begin
          vld_p2  <= 1'b0;
        end
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(load_head);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    addr_p1 <= addr_p0;
    if (push) begin
      fifo_word[wr_ptr] <= imemData_i[29:0];
      fifo_pc[wr_ptr]   <= addr_p1;
    end
  end

  assert property (@(posedge clock_i) disable iff (!resetn_i)
    !(push && !load_head && (fifo_cnt == CNT_W'(DEPTH))));

  assign imemReq_o           = vld_p0;
  assign imemAddr_o          = addr_p0;
  assign enable_o            = vld_p2;
  assign isBranch_o          = word_p2[29];
  assign instructionFormat_o = word_p2[28];
  assign opcode_o            = word_p2[27:21];
  assign primOperand_o       = word_p2[20:16];
  assign secOperand_o        = word_p2[15:0];
  assign pc_o                = pc_p2;
  assign flushBack_o         = flush_p2;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - bench for fetch_unit: a 16-bit instance under directed and
// random stimulus, plus a 4-bit instance free-running from PC 14.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable, stall, redirect;
  logic [15:0] raddr;
  logic        req, mvalid, en_o, isb, fmt, flush;
  logic [15:0] addr, pc_o, sec;
  logic [31:0] mdata;
  logic [6:0]  opc;
  logic [4:0]  prim;

  logic        req4, mvalid4, en4, isb4, fmt4, flush4;
  logic [3:0]  addr4, pc4;
  logic [31:0] mdata4;
  logic [6:0]  opc4;
  logic [4:0]  prim4;
  logic [15:0] sec4;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'd0), .DEPTH(2)) dut (
    .clock_i(clk), .resetn_i(resetn), .enable_i(enable), .stall_i(stall),
    .redirect_i(redirect), .redirectAddr_i(raddr),
    .imemReq_o(req), .imemAddr_o(addr), .imemValid_i(mvalid), .imemData_i(mdata),
    .enable_o(en_o), .isBranch_o(isb), .instructionFormat_o(fmt), .opcode_o(opc),
    .primOperand_o(prim), .secOperand_o(sec), .pc_o(pc_o), .flushBack_o(flush)
  );

  fetch_unit #(.ADDR_W(4), .RESET_PC(4'd14), .DEPTH(2)) dut4 (
    .clock_i(clk), .resetn_i(resetn), .enable_i(1'b1), .stall_i(1'b0),
    .redirect_i(1'b0), .redirectAddr_i(4'd0),
    .imemReq_o(req4), .imemAddr_o(addr4), .imemValid_i(mvalid4), .imemData_i(mdata4),
    .enable_o(en4), .isBranch_o(isb4), .instructionFormat_o(fmt4), .opcode_o(opc4),
    .primOperand_o(prim4), .secOperand_o(sec4), .pc_o(pc4), .flushBack_o(flush4)
  );

  // Instruction memories: one-cycle read latency.
  logic [31:0] mem  [0:65535];
  logic [31:0] mem4 [0:15];
  always @(posedge clk) begin
    mvalid  <= req;
    mdata   <= mem[addr];
    mvalid4 <= req4;
    mdata4  <= mem4[addr4];
  end

  int checks = 0;
  int failures = 0;

  // Reference state: next word decode should see, next address to request.
  logic [15:0] exp_pc, req_exp;
  logic [3:0]  exp4;
  logic        seen42;
  // Inputs seen at the last edge and outputs seen before it.
  logic        p_rst, p_redir, p_stall, p_en;
  logic [15:0] p_target;
  logic        s_en;
  logic [15:0] s_pc;
  logic [29:0] s_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    logic [29:0] f, f4;
    f  = {isb, fmt, opc, prim, sec};
    f4 = {isb4, fmt4, opc4, prim4, sec4};
    if (p_rst) begin
      chk("rst_en", 32'(en_o), 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_fields", 32'(f), 32'd0);
      chk("rst_pc", 32'(pc_o), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst4_en", 32'(en4), 32'd0);
      chk("rst4_pc", 32'(pc4), 32'd0);
      exp_pc  = 16'd0;
      req_exp = 16'd0;
      exp4    = 4'd14;
    end else begin
      if (s_en && !p_stall && !p_redir) exp_pc = exp_pc + 16'd1;
      if (p_redir) begin
        exp_pc  = p_target;
        req_exp = p_target;
        chk("redir_flush", 32'(flush), 32'd1);
        chk("redir_en", 32'(en_o), 32'd0);
        chk("redir_req", 32'(req), 32'd0);
      end else begin
        chk("flush_idle", 32'(flush), 32'd0);
        if (s_en && p_stall) begin
          chk("stall_hold_en", 32'(en_o), 32'd1);
          chk("stall_hold_pc", 32'(pc_o), 32'(s_pc));
          chk("stall_hold_fields", 32'(f), 32'(s_f));
        end
        if (!p_en) chk("noen_req", 32'(req), 32'd0);
      end
      if (en_o) begin
        chk("out_pc", 32'(pc_o), 32'(exp_pc));
        chk("out_fields", 32'(f), 32'(mem[exp_pc][29:0]));
      end
      if (en_o && pc_o == 16'h0042) begin
        seen42 = 1'b1;
        chk("f42_isBranch", 32'(isb), 32'd1);
        chk("f42_format", 32'(fmt), 32'd0);
        chk("f42_opcode", 32'(opc), 32'h51);
        chk("f42_prim", 32'(prim), 32'h0A);
        chk("f42_sec", 32'(sec), 32'h1234);
      end
      if (req) begin
        chk("req_addr", 32'(addr), 32'(req_exp));
        req_exp = req_exp + 16'd1;
      end
      if (en4) begin
        chk("w4_pc", 32'(pc4), 32'(exp4));
        chk("w4_fields", 32'(f4), 32'(mem4[exp4][29:0]));
        exp4 = exp4 + 4'd1;
      end
    end
    s_en = en_o;
    s_pc = pc_o;
    s_f  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    p_rst    = !resetn;
    p_redir  = redirect;
    p_target = raddr;
    p_stall  = stall;
    p_en     = enable;
    @(negedge clk);
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  seq4 [4];
    int          n;
    bit          got;
    seq4 = '{4'd14, 4'd15, 4'd0, 4'd1};
    for (int a = 0; a < 65536; a++) begin
      w = $urandom;
      mem[a] = {w[31:16], 16'(a)};
    end
    mem[16'h0042] = 32'h2A2A_1234;
    for (int a = 0; a < 16; a++) mem4[a] = $urandom;
    exp_pc = '0; req_exp = '0; exp4 = 4'd14; seen42 = 1'b0;
    s_en = 1'b0; s_pc = '0; s_f = '0;
    resetn = 1'b0; enable = 1'b0; stall = 1'b0; redirect = 1'b0; raddr = '0;
    tick();
    tick();

    // Reset release: latency, address stream and the 4-bit wrap.
    resetn = 1'b1;
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("lat_req", 32'(req), 32'd1);
      chk("lat_en", 32'(en_o), 32'(c >= 3));
      if (c >= 3) chk("lat_pc", 32'(pc_o), 32'(c - 3));
      if (c >= 3 && c <= 6) chk("w4_wrap_seq", 32'(pc4), 32'(seq4[c - 3]));
    end

    // Stall mid-stream for 5 cycles.
    stall = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n = n + int'(req);
    end
    chk("stall_reqs_le2", 32'(n <= 2), 32'd1);
    stall = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    // Redirect with a request in flight.
    chk("redir_inflight", 32'(req), 32'd1);
    redirect = 1'b1;
    raddr = 16'h0040;
    tick();
    redirect = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = en_o;
    end
    chk("redir_wait_en", 32'(en_o), 32'd1);
    chk("redir_first_pc", 32'(pc_o), 32'h40);
    tick();
    chk("redir_second_en", 32'(en_o), 32'd1);
    chk("redir_second_pc", 32'(pc_o), 32'h41);

    // Drop enable for 3 cycles.
    enable = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    enable = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("seen_0x42", 32'(seen42), 32'd1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 99) < 30);
      enable   = ($urandom_range(0, 99) < 85);
      redirect = ($urandom_range(0, 99) < 4);
      raddr    = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      tick();
    end

    // Reset in the middle of a stream.
    stall = 1'b0; enable = 1'b1; redirect = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. It is the producer side of the decode-stage input interface.
- Keeps the PC and issues word reads to a synchronous instruction memory with fixed 1-cycle latency.
- Splits each returned word into isBranch / format / opcode / primary / secondary fields for decode.
- Buffers in-flight responses in a small FIFO so that a decode stall never loses an instruction. A branch redirect flushes the FIFO and restarts fetch at the target address.

Parameters:
ADDR_W, 16, instruction address width (word addressed)
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, response FIFO entries (minimum 2)

Ports:
clock_i  in  1  clock, all logic on rising edge
resetn_i  in  1  synchronous reset, active-low
enable_i  in  1  fetch run enable; 0 = issue no new requests
stall_i  in  1  downstream stall; decode holds and does not consume
redirect_i  in  1  branch redirect pulse
redirectAddr_i  in  ADDR_W  redirect target
imemReq_o  out  1  memory read request
imemAddr_o  out  ADDR_W  memory read address
imemValid_i  in  1  read data valid, exactly 1 cycle after request
imemData_i  in  32  instruction word
enable_o  out  1  output fields valid
isBranch_o  out  1  imemData[29]
instructionFormat_o  out  1  imemData[28]; 1 = reg-imm, 0 = reg-reg
opcode_o  out  7  imemData[27:21]
primOperand_o  out  5  imemData[20:16]
secOperand_o  out  16  imemData[15:0]
pc_o  out  ADDR_W  address of the instruction on the outputs
flushBack_o  out  1  one-cycle flush pulse to decode

Behaviour:
- Clock is clock_i. Reset is resetn_i: one clock, synchronous, active-low.
- Reset (resetn_i = 0 at an edge):
  - PC <= RESET_PC; FIFO empty; inflight <= 0; drop flag <= 0.
  - imemReq_o, enable_o, flushBack_o <= 0.
  - All field outputs, pc_o and imemAddr_o <= 0.
  - Reset mid-operation discards every buffered and in-flight word. A response arriving in the cycle after reset is ignored.
- Outputs are all registered. Bits [31:30] of imemData_i are ignored.
- Consumption: the output stage is consumed at an edge where enable_o = 1 and stall_i = 0. While stall_i = 1, all outputs hold their values, including enable_o.
- Request issue, at each edge with no redirect:
  - Condition: enable_i = 1 and (fifoCount + inflight) < DEPTH, where inflight is the imemReq_o registered in the previous cycle.
  - When issued: imemReq_o <= 1, imemAddr_o <= PC, PC <= PC + 1.
  - PC wraps from 2^ADDR_W - 1 to 0.
  - Otherwise imemReq_o <= 0.
  - A slot freed by a pop in the same cycle is not counted.
- Response path, when imemValid_i = 1 and the word is not dropped:
  - Output stage empty or being consumed, and FIFO empty: the word bypasses straight into the output registers. enable_o = 1 in the next cycle.
  - Otherwise the word is pushed to the FIFO tail.
  - Whenever the output stage is empty or being consumed and the FIFO is non-empty, the FIFO head is loaded. FIFO order is preserved: the head is loaded before the new word.
- Latency and throughput:
  - Request in cycle N → response in N+1 → enable_o = 1 in N+2.
  - Unstalled throughput is 1 instruction per cycle.
- pc_o always carries the request address of the word currently on the outputs.
- Redirect (redirect_i = 1) has priority over stall, response and issue:
  - FIFO cleared; enable_o <= 0; flushBack_o <= 1 for exactly one cycle; PC <= redirectAddr_i; imemReq_o <= 0.
  - drop <= imemReq_o, so the response to a request made in the redirect cycle is discarded.
  - A response arriving in the redirect cycle itself is discarded.
  - The first request to the target is issued in the cycle after the redirect.
  - Back-to-back redirects: the last one wins.
- enable_i = 0: issue stops; in-flight responses still complete; the FIFO and output stage drain normally.
- Overflow is impossible by the issue rule. A valid response with the FIFO full is a design error; flag it with an assertion in simulation.

Test Plan:
- Release reset with enable_i = 1 and memory returning word = address → imemAddr_o 0, 1, 2… from cycle 1; enable_o from cycle 3 with pc_o 0, 1, 2… and secOperand_o = pc.
- Word 0x2A2A_1234 → isBranch_o = 1, instructionFormat_o = 0, opcode_o = 0x51, primOperand_o = 0x0A, secOperand_o = 0x1234.
- Assert stall_i for 5 cycles mid-stream → outputs frozen; at most 2 further requests issued; after release, pc_o continues consecutively with no gap or duplicate.
- redirect_i with redirectAddr_i = 0x40 while a request is in flight → flushBack_o pulses once; the stale word never reaches the outputs; next enable_o shows pc_o = 0x40, then 0x41.
- ADDR_W = 4, run from 14 → pc_o sequence 14, 15, 0, 1.
- Drop enable_i for 3 cycles → imemReq_o = 0 during the gap; buffered words still drain; fetch resumes at the correct PC. Assert resetn_i = 0 mid-stream → all outputs 0 at the next edge.
